// File: rtl/ccr_flag_unit_pkg.sv
// Shared definitions for the condition-code / branch-resolution unit:
// flag bit positions, branch encodings and the flag vector type.
package ccr_flag_unit_pkg;

    localparam int FLAG_W = 3;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef enum logic [1:0] {
        BR_JZ  = 2'b00,
        BR_JN  = 2'b01,
        BR_JC  = 2'b10,
        BR_JMP = 2'b11
    } br_type_e;

    // A branch is taken when its tested flag is set; JMP ignores the flags.
    function automatic logic branchCondMet(input br_type_e kind, input flags_t f);
        logic met;
        unique case (kind)
            BR_JZ:   met = f[FLAG_Z];
            BR_JN:   met = f[FLAG_N];
            BR_JC:   met = f[FLAG_C];
            default: met = 1'b1;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ccr_flag_unit_flag_shadow.sv
// Single-entry flag shadow used across interrupt entry and return,
// with a valid bit and a sticky error for restores from an empty shadow.
module flag_shadow
    import ccr_flag_unit_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   stall_i,
    input  logic   save_i,
    input  logic   restore_i,
    input  flags_t saveFlags_i,
    output flags_t shadowFlags_o,
    output logic   shadowValid_o,
    output logic   shadowErr_o
);

    flags_t shadow_q, shadow_d;
    logic   valid_q, valid_d;
    logic   err_q, err_d;

    // A save in the same cycle as a restore wins, so the entry stays valid
    // and holds the post-restore result computed by the top.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (!stall_i) begin
            if (restore_i) begin
                valid_d = 1'b0;
                if (!valid_q) begin
                    err_d = 1'b1;
                end
            end
            if (save_i) begin
                shadow_d = saveFlags_i;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign shadowFlags_o = shadow_q;
    assign shadowValid_o = valid_q;
    assign shadowErr_o   = err_q;

endmodule

// File: rtl/ccr_flag_unit.sv
// Condition-code register with same-cycle bypass into branch resolution,
// a registered redirect to fetch, and interrupt save/restore of the flags.
module ccr_flag_unit
    import ccr_flag_unit_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         alu_valid,
    input  logic [2:0]   alu_flag_we,
    input  logic         alu_neg,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         setc,
    input  logic         clrc,
    input  logic         br_valid,
    input  logic [1:0]   br_type,
    input  logic [N-1:0] br_target,
    input  logic         int_save,
    input  logic         int_restore,
    output logic [2:0]   flags,
    output logic         br_taken,
    output logic [N-1:0] br_pc,
    output logic         shadow_err
);

    flags_t         flags_q, flags_d;
    logic           brTaken_q;
    logic [N-1:0]   brPc_q;

    flags_t         shadowFlags;
    logic           shadowValid;
    logic           shadowErr;

    flags_t         aluResult;
    flags_t         startFlags;
    flags_t         aluFlags;
    flags_t         ovrFlags;
    br_type_e       brKind;
    logic           brHit;

    assign aluResult = {alu_neg, alu_zero, alu_carry};
    assign brKind    = br_type_e'(br_type);

    // Each stage sees the previous one: restore, ALU mask, carry override,
    // then branch resolution and clearing of the tested flag.
    always_comb begin
        startFlags = (int_restore && shadowValid) ? shadowFlags : flags_q;

        aluFlags = startFlags;
        if (alu_valid) begin
            for (int i = 0; i < FLAG_W; i++) begin
                if (alu_flag_we[i]) begin
                    aluFlags[i] = aluResult[i];
                end
            end
        end

        ovrFlags = aluFlags;
        if (setc) begin
            ovrFlags[FLAG_C] = 1'b1;
        end
        if (clrc) begin
            ovrFlags[FLAG_C] = 1'b0;
        end

        brHit   = br_valid && branchCondMet(brKind, ovrFlags);
        flags_d = ovrFlags;
        if (brHit) begin
            unique case (brKind)
                BR_JZ:   flags_d[FLAG_Z] = 1'b0;
                BR_JN:   flags_d[FLAG_N] = 1'b0;
                BR_JC:   flags_d[FLAG_C] = 1'b0;
                default: flags_d = ovrFlags;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= '0;
            brTaken_q <= 1'b0;
            brPc_q    <= '0;
        end else if (stall) begin
            brTaken_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            brTaken_q <= brHit;
            if (brHit) begin
                brPc_q <= br_target;
            end
        end
    end

    flag_shadow u_shadow (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .save_i        (int_save),
        .restore_i     (int_restore),
        .saveFlags_i   (flags_d),
        .shadowFlags_o (shadowFlags),
        .shadowValid_o (shadowValid),
        .shadowErr_o   (shadowErr)
    );

    assign flags      = flags_q;
    assign br_taken   = brTaken_q;
    assign br_pc      = brPc_q;
    assign shadow_err = shadowErr;

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Scoreboard bench for ccr_flag_unit: directed scenarios plus random
// traffic, compared against a behavioural model of the flag rules.
module tb_ccr_flag_unit;

    localparam int N = 16;

    typedef struct {
        logic         rst;
        logic         stall;
        logic         aluValid;
        logic [2:0]   aluWe;
        logic         aluN;
        logic         aluZ;
        logic         aluC;
        logic         setc;
        logic         clrc;
        logic         brValid;
        logic [1:0]   brType;
        logic [N-1:0] brTarget;
        logic         intSave;
        logic         intRestore;
    } stim_t;

    typedef struct {
        logic [2:0]   flags;
        logic         taken;
        logic [N-1:0] pc;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, stall, alu_valid, alu_neg, alu_zero, alu_carry;
    logic [2:0]   alu_flag_we;
    logic         setc, clrc, br_valid, int_save, int_restore;
    logic [1:0]   br_type;
    logic [N-1:0] br_target;
    logic [2:0]   flags;
    logic         br_taken;
    logic [N-1:0] br_pc;
    logic         shadow_err;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Model state: flags as separate bits, shadow as a value plus present bit.
    logic         mN = 0, mZ = 0, mC = 0;
    logic [2:0]   mShadow = 0;
    logic         mShadowFull = 0;
    logic         mErr = 0, mTaken = 0;
    logic [N-1:0] mPc = 0;

    ccr_flag_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_valid(alu_valid), .alu_flag_we(alu_flag_we),
        .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .setc(setc), .clrc(clrc),
        .br_valid(br_valid), .br_type(br_type), .br_target(br_target),
        .int_save(int_save), .int_restore(int_restore),
        .flags(flags), .br_taken(br_taken), .br_pc(br_pc),
        .shadow_err(shadow_err)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.stall = 0; s.aluValid = 0; s.aluWe = 0;
        s.aluN = 0; s.aluZ = 0; s.aluC = 0; s.setc = 0; s.clrc = 0;
        s.brValid = 0; s.brType = 0; s.brTarget = 0;
        s.intSave = 0; s.intRestore = 0;
        return s;
    endfunction

    task automatic modelStep(input stim_t s);
        logic n, z, c, hit;
        if (s.rst) begin
            {mN, mZ, mC} = 3'b000;
            mShadow = 0; mShadowFull = 0; mErr = 0; mTaken = 0; mPc = 0;
        end else if (s.stall) begin
            mTaken = 0;
        end else begin
            n = mN; z = mZ; c = mC;
            if (s.intRestore) begin
                if (mShadowFull) {n, z, c} = mShadow;
                else mErr = 1;
                mShadowFull = 0;
            end
            if (s.aluValid && s.aluWe[2]) n = s.aluN;
            if (s.aluValid && s.aluWe[1]) z = s.aluZ;
            if (s.aluValid && s.aluWe[0]) c = s.aluC;
            if (s.setc) c = 1;
            if (s.clrc) c = 0;
            hit = 0;
            if (s.brValid) begin
                if (s.brType == 2'd0 && z) begin hit = 1; z = 0; end
                if (s.brType == 2'd1 && n) begin hit = 1; n = 0; end
                if (s.brType == 2'd2 && c) begin hit = 1; c = 0; end
                if (s.brType == 2'd3) hit = 1;
            end
            mTaken = hit;
            if (hit) mPc = s.brTarget;
            if (s.intSave) begin
                mShadow = {n, z, c};
                mShadowFull = 1;
            end
            mN = n; mZ = z; mC = c;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; stall = s.stall; alu_valid = s.aluValid;
        alu_flag_we = s.aluWe; alu_neg = s.aluN; alu_zero = s.aluZ;
        alu_carry = s.aluC; setc = s.setc; clrc = s.clrc;
        br_valid = s.brValid; br_type = s.brType; br_target = s.brTarget;
        int_save = s.intSave; int_restore = s.intRestore;
        modelStep(s);
        e.flags = {mN, mZ, mC}; e.taken = mTaken; e.pc = mPc; e.err = mErr;
        expQ.push_back(e);
    endtask

    task automatic compare(input string name, input logic [N-1:0] got,
                           input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] f,
                               input logic t, input logic [N-1:0] pc,
                               input logic err);
        @(posedge clk);
        #2;
        compare({name, ".flags"}, N'(flags), N'(f));
        compare({name, ".taken"}, N'(br_taken), N'(t));
        compare({name, ".pc"}, br_pc, pc);
        compare({name, ".err"}, N'(shadow_err), N'(err));
    endtask

    // Monitor: outputs are presented every cycle, one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                compare("sb.flags", N'(flags), N'(e.flags));
                compare("sb.taken", N'(br_taken), N'(e.taken));
                compare("sb.pc", br_pc, e.pc);
                compare("sb.err", N'(shadow_err), N'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        applyStimulus(s);
        checkOutput("reset", 3'b000, 0, 16'h0000, 0);

        s = idle(); s.aluValid = 1; s.aluWe = 3'b011;
        s.aluN = 1; s.aluZ = 1; s.aluC = 1;
        applyStimulus(s);
        checkOutput("aluMask", 3'b011, 0, 16'h0000, 0);

        s = idle(); s.aluValid = 1; s.aluWe = 3'b010; s.aluZ = 1;
        s.brValid = 1; s.brType = 2'd0; s.brTarget = 16'h0040;
        applyStimulus(s);
        checkOutput("jzBypass", 3'b001, 1, 16'h0040, 0);

        s = idle(); s.clrc = 1;
        applyStimulus(s);
        s = idle(); s.brValid = 1; s.brType = 2'd2; s.brTarget = 16'h0099;
        applyStimulus(s);
        checkOutput("jcNotTaken", 3'b000, 0, 16'h0040, 0);

        s = idle(); s.setc = 1; s.clrc = 1;
        s.brValid = 1; s.brType = 2'd2; s.brTarget = 16'h0077;
        applyStimulus(s);
        checkOutput("setcClrc", 3'b000, 0, 16'h0040, 0);

        s = idle(); s.aluValid = 1; s.aluWe = 3'b111; s.aluN = 1; s.aluC = 1;
        applyStimulus(s);
        s = idle(); s.intSave = 1;
        applyStimulus(s);
        s = idle(); s.aluValid = 1; s.aluWe = 3'b111; s.aluZ = 1;
        applyStimulus(s);
        checkOutput("aluAfterSave", 3'b010, 0, 16'h0040, 0);
        s = idle(); s.intRestore = 1;
        applyStimulus(s);
        checkOutput("restore", 3'b101, 0, 16'h0040, 0);
        s = idle(); s.intRestore = 1;
        applyStimulus(s);
        checkOutput("restoreEmpty", 3'b101, 0, 16'h0040, 1);

        s = idle(); s.stall = 1; s.brValid = 1; s.brType = 2'd3;
        s.brTarget = 16'h1234; s.aluValid = 1; s.aluWe = 3'b111;
        applyStimulus(s);
        checkOutput("stallJmp", 3'b101, 0, 16'h0040, 1);

        s = idle(); s.rst = 1; s.brValid = 1; s.brType = 2'd3;
        s.brTarget = 16'h1234;
        applyStimulus(s);
        checkOutput("resetJmp", 3'b000, 0, 16'h0000, 0);

        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst        = ($urandom_range(0, 49) == 0);
            s.stall      = ($urandom_range(0, 5) == 0);
            s.aluValid   = $urandom_range(0, 1);
            s.aluWe      = 3'($urandom);
            s.aluN       = $urandom_range(0, 1);
            s.aluZ       = $urandom_range(0, 1);
            s.aluC       = $urandom_range(0, 1);
            s.setc       = ($urandom_range(0, 4) == 0);
            s.clrc       = ($urandom_range(0, 4) == 0);
            s.brValid    = $urandom_range(0, 1);
            s.brType     = 2'($urandom);
            s.brTarget   = N'($urandom);
            s.intSave    = ($urandom_range(0, 5) == 0);
            s.intRestore = ($urandom_range(0, 5) == 0);
            applyStimulus(s);
        end

        s = idle();
        applyStimulus(s);
        repeat (3) @(posedge clk);
        #2;
        compare("drain", N'(expQ.size()), N'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
